// File: rtl/fft_peak_finder_pkg.sv
// Shared constants and state encoding for the post-FFT peak search stage.
// N and M must track the FFT engine that fills the result memory.
package fft_peak_finder_pkg;

    localparam int N     = 1024;
    localparam int M     = 10;
    localparam int W     = 32;
    localparam int MAG_W = 2 * W + 1;

    localparam logic [M-1:0] FIRST_BIN = M'(1);
    localparam logic [M-1:0] LAST_BIN  = M'(N / 2);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SCAN  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/fft_peak_finder_cplx_mag_sq.sv
// Registered squared magnitude re^2 + im^2 with one cycle of latency.
// The full-width sum cannot overflow: each square fits 2W signed bits, the sum 2W+1 unsigned.
module cplx_mag_sq #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] re,
    input  logic signed [W-1:0] im,
    output logic [2*W:0]        mag
);

    logic signed [2*W-1:0] re_sq;
    logic signed [2*W-1:0] im_sq;

    assign re_sq = re * re;
    assign im_sq = im * im;

    // NOTE: registered state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
        end else begin
            mag <= (2*W+1)'(unsigned'(re_sq)) + (2*W+1)'(unsigned'(im_sq));
        end
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Scans FFT bins 1..N/2, tracks the strongest non-DC bin and its two neighbours' magnitudes.
// Start/Done/Ack handshake matches the FFT engine; all outputs are registered.
module fft_peak_finder
    import fft_peak_finder_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic                Ack,
    output logic                rd_en,
    output logic [M-1:0]        rd_addr,
    input  logic signed [W-1:0] rd_re,
    input  logic signed [W-1:0] rd_im,
    output logic                Busy,
    output logic                Done,
    output logic [M-1:0]        peak_bin,
    output logic [MAG_W-1:0]    peak_mag,
    output logic [MAG_W-1:0]    prev_mag,
    output logic [MAG_W-1:0]    next_mag
);

    state_t             state;
    logic               drain_cnt;
    logic               v1, v2;
    logic [M-1:0]       bin1, bin2;
    logic [MAG_W-1:0]   mag;
    logic [MAG_W-1:0]   last_mag;
    logic               pend_next;

    cplx_mag_sq #(.W(W)) u_mag (
        .clk   (Clk),
        .rst_n (Reset_n),
        .re    (rd_re),
        .im    (rd_im),
        .mag   (mag)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (Start) begin
                    state   <= ST_SCAN;
                    rd_en   <= 1'b1;
                    rd_addr <= FIRST_BIN;
                    Busy    <= 1'b1;
                end
                ST_SCAN: begin
                    if (rd_addr == LAST_BIN) begin
                        state     <= ST_DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles cover the memory read latency plus the magnitude register.
                    if (drain_cnt) begin
                        state <= ST_DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_DONE: if (Ack) begin
                    state <= ST_IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    rd_en <= 1'b0;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

    // Bin tags follow the data: one stage for the memory, one for the magnitude register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            bin1 <= '0;
            bin2 <= '0;
        end else begin
            v1   <= rd_en;
            v2   <= v1;
            bin1 <= rd_addr;
            bin2 <= bin1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            peak_bin  <= '0;
            peak_mag  <= '0;
            prev_mag  <= '0;
            next_mag  <= '0;
            last_mag  <= '0;
            pend_next <= 1'b0;
        end else if (state == ST_IDLE && Start) begin
            peak_bin  <= '0;
            peak_mag  <= '0;
            prev_mag  <= '0;
            next_mag  <= '0;
            last_mag  <= '0;
            pend_next <= 1'b0;
        end else if (v2) begin
            last_mag <= mag;
            if (bin2 == FIRST_BIN) begin
                peak_bin  <= bin2;
                peak_mag  <= mag;
                prev_mag  <= '0;
                pend_next <= 1'b1;
            end else if (bin2 != LAST_BIN && mag > peak_mag) begin
                // Strictly greater keeps the lowest index on ties.
                peak_bin  <= bin2;
                peak_mag  <= mag;
                prev_mag  <= last_mag;
                pend_next <= 1'b1;
            end else begin
                if (pend_next) next_mag <= mag;
                pend_next <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder: directed spectra, handshake and reset cases,
// plus randomized spectra scored against a direct argmax model of the bin magnitudes.
module tb_fft_peak_finder;
    import fft_peak_finder_pkg::*;

    logic                Clk;
    logic                Reset_n;
    logic                Start;
    logic                Ack;
    logic                rd_en;
    logic [M-1:0]        rd_addr;
    logic signed [W-1:0] rd_re;
    logic signed [W-1:0] rd_im;
    logic                Busy;
    logic                Done;
    logic [M-1:0]        peak_bin;
    logic [MAG_W-1:0]    peak_mag;
    logic [MAG_W-1:0]    prev_mag;
    logic [MAG_W-1:0]    next_mag;

    logic signed [W-1:0] mem_re [N];
    logic signed [W-1:0] mem_im [N];

    int n_tests = 0;
    int n_fail  = 0;

    fft_peak_finder dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Ack      (Ack),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_re    (rd_re),
        .rd_im    (rd_im),
        .Busy     (Busy),
        .Done     (Done),
        .peak_bin (peak_bin),
        .peak_mag (peak_mag),
        .prev_mag (prev_mag),
        .next_mag (next_mag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous-read result memory
    always @(posedge Clk) begin
        if (rd_en) begin
            rd_re <= mem_re[rd_addr];
            rd_im <= mem_im[rd_addr];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MAG_W-1:0] msq(input int k);
        logic signed [MAG_W:0] r, i;
        r = mem_re[k];
        i = mem_im[k];
        return MAG_W'(r * r + i * i);
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < N; k++) begin
            mem_re[k] = '0;
            mem_im[k] = '0;
        end
    endtask

    task automatic check_peak(input string tag, input logic [M-1:0] b,
                              input logic [MAG_W-1:0] pk, input logic [MAG_W-1:0] pv,
                              input logic [MAG_W-1:0] nx);
        check({tag, ".bin"},  peak_bin, b);
        check({tag, ".peak"}, peak_mag, pk);
        check({tag, ".prev"}, prev_mag, pv);
        check({tag, ".next"}, next_mag, nx);
    endtask

    task automatic check_model(input string tag);
        int best;
        best = 1;
        for (int k = 2; k < N / 2; k++)
            if (msq(k) > msq(best)) best = k;
        check_peak(tag, M'(best), msq(best), (best == 1) ? '0 : msq(best - 1), msq(best + 1));
    endtask

    // mode 0: plain run; 1: stray Start/Ack during SCAN; 2: assert reset at cycle 200
    task automatic run_search(input int mode, output int cycles);
        Start = 1'b1;
        @(posedge Clk); #1;
        Start  = 1'b0;
        cycles = 1;
        while (!Done && cycles < 2000) begin
            if (mode == 0 && cycles == 10) check("busy_scan", {Busy, rd_en}, 2'b11);
            if (mode == 1) begin
                Start = (cycles == 100);
                Ack   = (cycles >= 150 && cycles < 155);
            end
            if (mode == 2 && cycles == 200) begin
                Reset_n = 1'b0;
                return;
            end
            @(posedge Clk); #1;
            cycles++;
        end
        Start = 1'b0;
        Ack   = 1'b0;
        if (!Done) check("done_timeout", Done, 1'b1);
    endtask

    task automatic ack_results();
        Ack = 1'b1;
        @(posedge Clk); #1;
        Ack = 1'b0;
        check("done_fall", {Done, Busy}, 2'b00);
    endtask

    task automatic single_tone();
        clear_mem();
        mem_re[37] = 1000;
    endtask

    int cyc;
    logic [MAG_W-1:0] exp_big;

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        Ack     = 1'b0;
        clear_mem();
        #25 Reset_n = 1'b1;
        @(posedge Clk); #1;

        check("reset_ctrl", {rd_en, rd_addr, Busy, Done}, '0);
        check_peak("reset", '0, '0, '0, '0);

        single_tone();
        run_search(0, cyc);
        check("tone_latency", cyc, 515);
        check("tone_busy", Busy, 1'b0);
        check_peak("tone", 37, 1000000, 0, 0);
        ack_results();

        clear_mem();
        mem_re[0]  = 30000;  mem_im[0]  = 30000;
        mem_im[10] = -500;   mem_im[20] = -500;
        mem_re[9]  = 3;      mem_im[9]  = 4;
        mem_re[11] = 3;      mem_im[11] = 4;
        run_search(0, cyc);
        check_peak("tie", 10, 250000, 25, 25);
        ack_results();

        clear_mem();
        mem_re[511] = -32'sd1073741824;
        mem_im[511] = -32'sd1073741824;
        mem_re[510] = 1;
        mem_im[512] = 3;
        run_search(0, cyc);
        exp_big = '0;
        exp_big[61] = 1'b1;
        check_peak("edge", 511, exp_big, 1, 9);
        ack_results();

        clear_mem();
        run_search(0, cyc);
        check_peak("zero", 1, 0, 0, 0);
        ack_results();

        single_tone();
        run_search(1, cyc);
        check("hs_latency", cyc, 515);
        check_peak("hs", 37, 1000000, 0, 0);
        ack_results();
        repeat (3) @(posedge Clk);
        #1;
        check("idle_hold_ctrl", {Busy, Done}, 2'b00);
        check_peak("idle_hold", 37, 1000000, 0, 0);

        run_search(2, cyc);
        #1;
        check("rst_ctrl", {rd_en, rd_addr, Busy, Done}, '0);
        check_peak("rst", '0, '0, '0, '0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        run_search(0, cyc);
        check("rst_rerun_latency", cyc, 515);
        check_peak("rst_rerun", 37, 1000000, 0, 0);
        ack_results();

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(1, 0) == 0) begin
                    mem_re[k] = '0;
                    mem_im[k] = '0;
                end else if (t % 2 == 0) begin
                    mem_re[k] = $signed($urandom_range(6, 0)) - 3;
                    mem_im[k] = $signed($urandom_range(6, 0)) - 3;
                end else begin
                    mem_re[k] = $urandom;
                    mem_im[k] = $urandom;
                end
            end
            run_search(0, cyc);
            check($sformatf("rand%0d_latency", t), cyc, 515);
            check_model($sformatf("rand%0d", t));
            ack_results();
            @(posedge Clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
